// File: rtl/job_sequencer_pkg.sv
// Purpose: shared encodings and defaults for the job sequencer slice.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package job_sequencer_pkg;

  // Default width of the job tag carried end to end.
  localparam int ID_W_DEF = 4;

  // Sequencer state encoding, 3 bits.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ISSUE   = 3'd1,
    ST_WAIT    = 3'd2,
    ST_DONE_OK = 3'd3,
    ST_DONE_TO = 3'd4,
    ST_GAP     = 3'd5
  } state_e;

endpackage

// File: rtl/job_sequencer_if.sv
// Purpose: bundles the host request, engine and completion signals of the sequencer.
// Latency: n/a (wires only).
// Backpressure: req_ready throttles req_valid; the engine and completion sides have none.
// Ports: master = host/engine side (drives req_*, eng_done); slave = sequencer side.
interface job_sequencer_if import job_sequencer_pkg::*; #(
  parameter int ID_W  = ID_W_DEF,
  parameter int CNT_W = 8
);
  logic             req_valid;
  logic             req_ready;
  logic [ID_W-1:0]  req_id;
  logic             eng_start;
  logic             eng_done;
  logic             busy;
  logic [ID_W-1:0]  cur_id;
  logic             cpl_valid;
  logic [ID_W-1:0]  cpl_id;
  logic             cpl_timeout;
  logic [CNT_W-1:0] job_count;
  logic             err_stray;

  modport master (
    output req_valid, req_id, eng_done,
    input  req_ready, eng_start, busy, cur_id, cpl_valid, cpl_id, cpl_timeout,
           job_count, err_stray
  );

  modport slave (
    input  req_valid, req_id, eng_done,
    output req_ready, eng_start, busy, cur_id, cpl_valid, cpl_id, cpl_timeout,
           job_count, err_stray
  );
endinterface

// File: rtl/job_sequencer_fifo.sv
// Purpose: small synchronous request FIFO holding job tags (module job_fifo).
// Latency: a push is visible at the head on the next cycle; the head is read combinationally.
// Backpressure: pushes while full and pops while empty are dropped; o_full/o_empty flag it.
// Ports: clk, rst_n; i_push/i_dat write side; i_pop read side; o_head, o_full, o_empty.
module job_fifo #(
  parameter int ID_W  = 4,
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_push,
  input  logic [ID_W-1:0] i_dat,
  input  logic            i_pop,
  output logic [ID_W-1:0] o_head,
  output logic            o_full,
  output logic            o_empty
);
  localparam int AW = $clog2(DEPTH);

  logic [ID_W-1:0] r_mem [DEPTH];
  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0]     r_wr_ptr;
  logic [AW:0]     r_rd_ptr;
  logic            w_push;
  logic            w_pop;

  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_head  = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= i_dat;
  end
endmodule

// File: rtl/job_sequencer.sv
// Purpose: queues job requests and runs them one at a time on the engine, with a watchdog.
// Latency: request accepted in cycle 0 into an idle, empty block starts the engine in cycle 2;
//          completion strobe one cycle after done/timeout; next start 2+GAP_CYC cycles later.
// Backpressure: req_ready drops while the request FIFO is full; engine side has none.
// Ports: clk, rst_n (async, active-low); bus = job_sequencer_if.slave carrying req_*,
//        eng_start/eng_done, busy, cur_id, cpl_valid/cpl_id/cpl_timeout, job_count, err_stray.
module job_sequencer import job_sequencer_pkg::*; #(
  parameter int ID_W        = ID_W_DEF,
  parameter int DEPTH       = 4,
  parameter int TIMEOUT_CYC = 16,
  parameter int GAP_CYC     = 1,
  parameter int CNT_W       = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  job_sequencer_if.slave bus
);
  localparam int TMR_W = $clog2(TIMEOUT_CYC);
  localparam int GAP_W = (GAP_CYC < 2) ? 1 : $clog2(GAP_CYC);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);

  state_e           r_state;
  state_e           w_state_nxt;
  logic             w_pop;
  logic [ID_W-1:0]  w_head;
  logic             w_full;
  logic             w_empty;
  logic [TMR_W-1:0] r_timer;
  logic [GAP_W-1:0] r_gap;
  logic [ID_W-1:0]  r_cur_id;
  logic             r_cpl_valid;
  logic [ID_W-1:0]  r_cpl_id;
  logic             r_cpl_timeout;
  logic [CNT_W-1:0] r_job_count;
  logic             r_err_stray;
  logic             w_wait_exit;

  job_fifo #(.ID_W(ID_W), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (bus.req_valid),
    .i_dat   (bus.req_id),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_empty) begin
          w_state_nxt = ST_ISSUE;
          w_pop       = 1'b1;
        end
      end
      ST_ISSUE: w_state_nxt = ST_WAIT;
      ST_WAIT: begin
        // A done arriving on the last timer cycle still counts as success.
        if (bus.eng_done)            w_state_nxt = ST_DONE_OK;
        else if (r_timer == TMR_LAST) w_state_nxt = ST_DONE_TO;
      end
      ST_DONE_OK, ST_DONE_TO: w_state_nxt = (GAP_CYC > 0) ? ST_GAP : ST_IDLE;
      ST_GAP: begin
        if (r_gap == GAP_LAST) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_wait_exit = (r_state == ST_WAIT) && (w_state_nxt != ST_WAIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_timer       <= '0;
      r_gap         <= '0;
      r_cur_id      <= '0;
      r_cpl_valid   <= 1'b0;
      r_cpl_id      <= '0;
      r_cpl_timeout <= 1'b0;
      r_job_count   <= '0;
      r_err_stray   <= 1'b0;
    end else begin
      if (r_state == ST_ISSUE)     r_timer <= '0;
      else if (r_state == ST_WAIT) r_timer <= r_timer + 1'b1;

      if (r_state == ST_GAP) r_gap <= r_gap + 1'b1;
      else                   r_gap <= '0;

      if (w_pop) r_cur_id <= w_head;

      // Completion fields are registered so the strobe lines up with DONE_*.
      r_cpl_valid   <= w_wait_exit;
      r_cpl_timeout <= w_wait_exit && (w_state_nxt == ST_DONE_TO);
      if (w_wait_exit) r_cpl_id <= r_cur_id;

      if (w_wait_exit && (w_state_nxt == ST_DONE_OK)) r_job_count <= r_job_count + 1'b1;

      if (bus.eng_done && (r_state != ST_WAIT)) r_err_stray <= 1'b1;
    end
  end

  assign bus.req_ready   = !w_full;
  assign bus.eng_start   = (r_state == ST_ISSUE);
  assign bus.busy        = (r_state != ST_IDLE) || !w_empty;
  assign bus.cur_id      = r_cur_id;
  assign bus.cpl_valid   = r_cpl_valid;
  assign bus.cpl_id      = r_cpl_id;
  assign bus.cpl_timeout = r_cpl_timeout;
  assign bus.job_count   = r_job_count;
  assign bus.err_stray   = r_err_stray;
endmodule

// File: tb/tb_job_sequencer.sv
// Purpose: randomized and directed bench for job_sequencer against a timestamp-based model.
// Latency: n/a.
// Backpressure: requests are held until req_ready accepts them.
module tb_job_sequencer;
  localparam int ID_W  = 4;
  localparam int DEPTH = 4;
  localparam int TMO   = 16;
  localparam int GAP   = 1;
  localparam int CNT_W = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  job_sequencer_if #(.ID_W(ID_W), .CNT_W(CNT_W)) bus();

  job_sequencer #(
    .ID_W(ID_W), .DEPTH(DEPTH), .TIMEOUT_CYC(TMO), .GAP_CYC(GAP), .CNT_W(CNT_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: pending queue plus the cycle numbers at which the in-flight job starts,
  // completes and at which the block may next pick a job.
  int  mq[$];
  bit  m_job = 0;
  int  m_tstart = -1;
  int  m_tcpl = -1;
  int  m_tfree = 0;
  int  m_cur = 0;
  int  m_cnt = 0;
  bit  m_stray = 0;
  bit  m_to = 0;

  // Observations of the DUT used by the directed checks.
  int last_start_n = -1, last_cpl_n = -1, last_cpl_id = -1, last_cpl_to = -1;
  int start_cnt = 0, cpl_cnt = 0, nready_cnt = 0;
  int cpl_ids[$];
  int cpl_jc[$];

  function automatic void model_reset();
    mq.delete();
    m_job = 0; m_tstart = -1; m_tcpl = -1; m_tfree = 0;
    m_cur = 0; m_cnt = 0; m_stray = 0; m_to = 0;
  endfunction

  always @(negedge clk) begin : cmp
    int  n, sz;
    bit  idle_n, in_wait;
    if (!rst_n) begin
      model_reset();
    end else begin
      n       = cyc;
      sz      = mq.size();
      idle_n  = !m_job && (n >= m_tfree);
      in_wait = m_job && (n > m_tstart) && (m_tcpl < 0);

      chk("req_ready", bus.req_ready, sz < DEPTH);
      chk("busy", bus.busy, !idle_n || sz > 0);
      chk("eng_start", bus.eng_start, m_job && n == m_tstart);
      chk("cpl_valid", bus.cpl_valid, m_job && n == m_tcpl);
      chk("cur_id", bus.cur_id, m_cur);
      chk("job_count", bus.job_count, m_cnt);
      chk("err_stray", bus.err_stray, m_stray);
      if (m_job && n == m_tcpl) begin
        chk("cpl_id", bus.cpl_id, m_cur);
        chk("cpl_timeout", bus.cpl_timeout, m_to);
      end

      if (bus.eng_start) begin last_start_n = n; start_cnt++; end
      if (bus.cpl_valid) begin
        last_cpl_n = n; last_cpl_id = bus.cpl_id; last_cpl_to = bus.cpl_timeout;
        cpl_cnt++; cpl_ids.push_back(bus.cpl_id); cpl_jc.push_back(bus.job_count);
      end
      if (!bus.req_ready) nready_cnt++;

      // Advance the model across the coming clock edge.
      if (in_wait) begin
        if (bus.eng_done) begin
          m_tcpl = n + 1; m_to = 0; m_cnt = (m_cnt + 1) % (1 << CNT_W);
        end else if (n - m_tstart == TMO) begin
          m_tcpl = n + 1; m_to = 1;
        end
      end else if (bus.eng_done) begin
        m_stray = 1;
      end
      if (m_job && n == m_tcpl) begin
        m_job = 0; m_tfree = n + 1 + GAP;
      end
      if (idle_n && sz > 0) begin
        m_cur = mq.pop_front(); m_job = 1; m_tstart = n + 1; m_tcpl = -1;
      end
      if (bus.req_valid && sz < DEPTH) mq.push_back(int'(bus.req_id));
    end
  end

  // Engine model: answers each start after eng_delay cycles (0 = never), or a random
  // 1..20 cycles with occasional stray pulses when eng_rand is set.
  int eng_delay = 2;
  bit eng_rand = 0;
  bit stray_pulse = 0;
  initial begin : engine
    int cd, k;
    bit d;
    cd = -1;
    bus.eng_done = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      d = 0;
      if (!rst_n) begin
        cd = -1;
      end else begin
        if (cd > 0) begin
          cd--;
          if (cd == 0) begin d = 1; cd = -1; end
        end
        if (bus.eng_start) begin
          k  = eng_rand ? int'($urandom_range(1, 20)) : eng_delay;
          cd = (k == 0) ? -1 : k;
        end
        if (eng_rand && $urandom_range(0, 99) < 3) d = 1;
      end
      bus.eng_done = d | stray_pulse;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int id);
    bit done_p;
    done_p = 0;
    bus.req_valid = 1'b1;
    bus.req_id    = ID_W'(id);
    for (int t = 0; t < 200 && !done_p; t++) begin
      @(negedge clk);
      if (bus.req_ready) done_p = 1;
      tick();
    end
    if (!done_p) chk("push_accept_timeout", 0, 1);
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_idle(input int lim);
    bit ok;
    ok = 0;
    for (int t = 0; t < lim && !ok; t++) begin
      tick();
      if (!bus.busy) ok = 1;
    end
    if (!ok) chk("idle_timeout", 0, 1);
  endtask

  task automatic wait_cpl(input int n0, input int lim);
    bit ok;
    ok = 0;
    for (int t = 0; t < lim && !ok; t++) begin
      tick();
      if (cpl_cnt > n0) ok = 1;
    end
    if (!ok) chk("cpl_timeout_wait", 0, 1);
  endtask

  task automatic wait_start(input int n0, input int lim);
    bit ok;
    ok = 0;
    for (int t = 0; t < lim && !ok; t++) begin
      tick();
      if (start_cnt > n0) ok = 1;
    end
    if (!ok) chk("start_timeout_wait", 0, 1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, bus.req_ready, 1);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_eng_start"}, bus.eng_start, 0);
    chk({tag, "_cpl_valid"}, bus.cpl_valid, 0);
    chk({tag, "_cur_id"}, bus.cur_id, 0);
    chk({tag, "_cpl_id"}, bus.cpl_id, 0);
    chk({tag, "_cpl_timeout"}, bus.cpl_timeout, 0);
    chk({tag, "_job_count"}, bus.job_count, 0);
    chk({tag, "_err_stray"}, bus.err_stray, 0);
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int p, c0, n0, s0, s1, c1, mk, nr0;
    int exp_jc[5];
    exp_jc = '{1, 2, 3, 0, 1};
    bus.req_valid = 1'b0;
    bus.req_id    = '0;

    // Reset state.
    tick();
    chk_reset_outputs("reset");
    tick();
    #2 rst_n = 1'b1;
    repeat (3) tick();

    // Single job, engine answers 2 cycles after start.
    eng_delay = 2;
    p = cyc;
    push(5);
    repeat (10) tick();
    chk("single_start_lat", last_start_n - p, 2);
    chk("single_cpl_lat", last_cpl_n - p, 5);
    chk("single_cpl_id", last_cpl_id, 5);
    chk("single_cpl_to", last_cpl_to, 0);
    chk("single_job_count", bus.job_count, 1);
    chk("single_busy_after", bus.busy, 0);

    // FIFO fill with a slow engine; the sixth request has to wait for a pop.
    eng_delay = 10;
    mk  = cpl_ids.size();
    nr0 = nready_cnt;
    for (int i = 1; i <= 6; i++) push(i);
    wait_idle(400);
    chk("fill_full_seen", nready_cnt > nr0, 1);
    chk("fill_cpl_count", cpl_ids.size() - mk, 6);
    if (cpl_ids.size() - mk >= 6)
      for (int i = 0; i < 6; i++) chk("fill_order", cpl_ids[mk + i], i + 1);

    // Timeout, then a late done that must flag a stray.
    eng_delay = 0;
    c0 = bus.job_count;
    n0 = cpl_cnt;
    push(9);
    wait_cpl(n0, 100);
    chk("to_cpl_to", last_cpl_to, 1);
    chk("to_cpl_id", last_cpl_id, 9);
    chk("to_latency", last_cpl_n - (last_start_n + 1), TMO);
    chk("to_job_count", bus.job_count, c0);
    chk("to_stray_before", bus.err_stray, 0);
    tick();
    tick();
    stray_pulse = 1;
    tick();
    stray_pulse = 0;
    chk("to_stray_after", bus.err_stray, 1);
    wait_idle(50);

    // Done on the very last timer cycle wins over the timeout.
    eng_delay = TMO;
    c0 = bus.job_count;
    n0 = cpl_cnt;
    push(7);
    wait_cpl(n0, 100);
    chk("race_cpl_to", last_cpl_to, 0);
    chk("race_latency", last_cpl_n - (last_start_n + 1), TMO);
    chk("race_job_count", bus.job_count, (c0 + 1) % (1 << CNT_W));
    wait_idle(50);

    // Reset mid-WAIT with two jobs still queued.
    eng_delay = 0;
    s0 = start_cnt;
    push(11);
    push(12);
    push(13);
    wait_start(s0, 50);
    repeat (4) tick();
    #2 rst_n = 1'b0;
    #1 chk_reset_outputs("midrst");
    @(posedge clk);
    #3 rst_n = 1'b1;
    s1 = start_cnt;
    c1 = cpl_cnt;
    repeat (40) tick();
    chk("midrst_no_start", start_cnt, s1);
    chk("midrst_no_cpl", cpl_cnt, c1);
    chk("midrst_req_ready", bus.req_ready, 1);
    chk("midrst_job_count", bus.job_count, 0);

    // Counter wrap with a 2-bit job counter.
    eng_delay = 2;
    mk = cpl_jc.size();
    for (int i = 1; i <= 5; i++) push(i);
    wait_idle(200);
    chk("wrap_cpl_count", cpl_jc.size() - mk, 5);
    if (cpl_jc.size() - mk >= 5)
      for (int i = 0; i < 5; i++) chk("wrap_seq", cpl_jc[mk + i], exp_jc[i]);

    // Random traffic against the model.
    eng_rand = 1;
    repeat (600) begin
      bus.req_valid = ($urandom_range(0, 99) < 40);
      bus.req_id    = ID_W'($urandom_range(0, 15));
      tick();
    end
    bus.req_valid = 1'b0;
    eng_rand = 0;
    wait_idle(3000);
    repeat (30) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
